// File: rtl/conv_relu_pool_stream.sv
// Captures a float16 result frame, applies optional ReLU, max-pools each channel
// with a PxP window (stride P) and streams the pooled values one per beat.
module conv_relu_pool_stream #(
   parameter int DATA_WIDTH     = 16,
   parameter int OUTPUT_CHANNEL = 2,
   parameter int RESULT_LENGTH  = 2,
   parameter int RESULT_WIDTH   = 2,
   parameter int POOL_SIZE      = 2,
   parameter int RELU_EN        = 1,
   localparam int CH_W = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1,
   localparam int N    = OUTPUT_CHANNEL * RESULT_LENGTH * RESULT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N*DATA_WIDTH-1:0] result,
   input  logic                    cc_valid,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic [CH_W-1:0]         out_channel,
   output logic                    busy,
   output logic [7:0]              drop_cnt
);

   localparam int DW    = DATA_WIDTH;
   localparam int PL    = RESULT_LENGTH / POOL_SIZE;
   localparam int PW    = RESULT_WIDTH / POOL_SIZE;
   localparam int M     = OUTPUT_CHANNEL * PL * PW;
   localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

   state_t             state;
   state_t             state_nx;
   logic               cc_valid_q;
   logic               trigger;
   logic               accept;
   logic [N*DW-1:0]    frame_q;
   logic [N*DW-1:0]    frame_in;
   logic [IDX_W-1:0]   index;
   int                 sel;
   int                 sel_c;
   int                 sel_pr;
   int                 sel_pc;
   logic [DW-1:0]      beat_data;
   logic [CH_W-1:0]    beat_chan;
   logic               beat_last;

   // Handshake: a beat transfers on any edge where out_valid & out_ready; once
   // out_valid is raised it stays high and all outputs hold until that transfer.
   assign trigger = cc_valid & ~cc_valid_q;
   assign accept  = out_valid & out_ready;

   // Sign-magnitude to unsigned ordering key: negatives inverted, positives offset above them.
   function automatic logic [DW-1:0] order_key(input logic [DW-1:0] x);
      order_key = x[DW-1] ? ~x : (x | {1'b1, {(DW-1){1'b0}}});
   endfunction

   always_comb begin
      frame_in = result;
      for (int e = 0; e < N; e++) begin
         if ((RELU_EN != 0) && result[e*DW + DW-1])
            frame_in[e*DW +: DW] = '0;
      end
   end

   // Beat being prepared: beat 0 during LOAD, otherwise the one after the current index.
   always_comb begin
      sel = (state == S_LOAD) ? 0 : int'(index) + 1;
      if (sel >= M)
         sel = M - 1;
      sel_c  = sel / (PL * PW);
      sel_pr = (sel / PW) % PL;
      sel_pc = sel % PW;
   end

   always_comb begin
      int e;
      logic [DW-1:0] x;
      e = (sel_c * RESULT_LENGTH + sel_pr * POOL_SIZE) * RESULT_WIDTH + sel_pc * POOL_SIZE;
      beat_data = frame_q[e*DW +: DW];
      for (int r = 0; r < POOL_SIZE; r++) begin
         for (int k = 0; k < POOL_SIZE; k++) begin
            e = (sel_c * RESULT_LENGTH + sel_pr * POOL_SIZE + r) * RESULT_WIDTH
                + sel_pc * POOL_SIZE + k;
            x = frame_q[e*DW +: DW];
            if (order_key(x) > order_key(beat_data))
               beat_data = x;
         end
      end
      beat_chan = CH_W'(sel_c);
      beat_last = (sel == M - 1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (trigger) state_nx = S_LOAD;
         S_LOAD:   state_nx = S_STREAM;
         S_STREAM: if (accept && out_last) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cc_valid_q  <= 1'b0;
         frame_q     <= '0;
         index       <= '0;
         busy        <= 1'b0;
         out_data    <= '0;
         out_channel <= '0;
         out_last    <= 1'b0;
         out_valid   <= 1'b0;
         drop_cnt    <= 8'd0;
      end else begin
         cc_valid_q <= cc_valid;
         if (trigger && (state != S_IDLE) && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
         case (state)
            S_IDLE: begin
               if (trigger) begin
                  frame_q <= frame_in;
                  busy    <= 1'b1;
                  index   <= '0;
               end
            end
            S_LOAD: begin
               out_data    <= beat_data;
               out_channel <= beat_chan;
               out_last    <= beat_last;
               out_valid   <= 1'b1;
            end
            S_STREAM: begin
               if (accept) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     index       <= index + IDX_W'(1);
                     out_data    <= beat_data;
                     out_channel <= beat_chan;
                     out_last    <= beat_last;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
